// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle control unit:
//               FSM state enum, instruction-class enum, supported opcode
//               values, and the ALUOp / ALUSrcB field encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_BRANCH = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_RTYPE   = 3'd3,
    CL_ITYPE   = 3'd4,
    CL_BRANCH  = 3'd5,
    CL_ILLEGAL = 3'd6
  } class_t;

  // Supported opcode fields
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  // ALUOp encodings
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] c_ALUOP_AND   = 2'b11;

  // ALUSrcB encodings
  localparam logic [1:0] c_SRCB_RS2  = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR = 2'b01;
  localparam logic [1:0] c_SRCB_IMM  = 2'b10;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_opcode_decode
// Description : Purely combinational opcode-to-class decoder. Any opcode
//               outside the supported set maps to CL_ILLEGAL.
// Ports       : i_opcode [6:0] - instruction register opcode field
//               o_class        - decoded instruction class
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [6:0] i_opcode,
  output class_t     o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      c_OP_LOAD:   o_class = CL_LOAD;
      c_OP_STORE:  o_class = CL_STORE;
      c_OP_RTYPE:  o_class = CL_RTYPE;
      c_OP_ITYPE:  o_class = CL_ITYPE;
      c_OP_BRANCH: o_class = CL_BRANCH;
      default:     o_class = CL_ILLEGAL;
    endcase
  end

endmodule : mc_opcode_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for a multicycle RISC-V subset datapath
//               (lh, sh, add/or/sll, andi, bne). Sequences FETCH, DECODE,
//               EXEC, BRANCH, MEM, WB and a sticky TRAP for unsupported
//               opcodes.
// Ports       : clk, rst_n (async active-low), opcode[6:0], zero, mem_ready
//               PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//               MemtoReg, RegWrite, PCSource, ALUSrcA, ALUSrcB[1:0],
//               ALUOp[1:0], illegal
//               cycle_cnt[31:0], instret_cnt[31:0] (PERF_CNT_EN only)
// Options     : PERF_CNT_EN - adds free-running cycle and retired-
//               instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  class_t r_class;
  class_t w_class;
  logic   r_illegal;

  // The branch condition is applied by the datapath (PCWriteCond & ~zero),
  // so the FSM itself never looks at the flag.
  logic   w_unused_zero;
  assign w_unused_zero = zero;

  mc_opcode_decode u_decode (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  // --------------------------------------------------------------------------
  // State, class and sticky-illegal registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class <= CL_NONE;
    end else if (r_state == ST_DECODE) begin
      r_class <= w_class;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == ST_DECODE) && (w_class == CL_ILLEGAL)) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = c_SRCB_RS2;
    ALUOp       = c_ALUOP_ADD;

    case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = c_SRCB_FOUR;
        ALUOp   = c_ALUOP_ADD;
        // IR and PC+4 are captured only in the cycle memory delivers the word
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        w_next  = mem_ready ? ST_DECODE : ST_FETCH;
      end

      ST_DECODE: begin
        // Speculative branch target (PC + imm) into ALUOut
        ALUSrcB = c_SRCB_IMM;
        ALUOp   = c_ALUOP_ADD;
        // The class register is loaded at the end of this cycle, so route
        // on the decoder output directly.
        case (w_class)
          CL_BRANCH:  w_next = ST_BRANCH;
          CL_ILLEGAL: w_next = ST_TRAP;
          default:    w_next = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        ALUSrcA = 1'b1;
        case (r_class)
          CL_LOAD, CL_STORE: begin
            ALUSrcB = c_SRCB_IMM;
            ALUOp   = c_ALUOP_ADD;
            w_next  = ST_MEM;
          end
          CL_RTYPE: begin
            ALUSrcB = c_SRCB_RS2;
            ALUOp   = c_ALUOP_FUNCT;
            w_next  = ST_WB;
          end
          CL_ITYPE: begin
            ALUSrcB = c_SRCB_IMM;
            ALUOp   = c_ALUOP_AND;
            w_next  = ST_WB;
          end
          default: begin
            w_next  = ST_FETCH;
          end
        endcase
      end

      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = c_SRCB_RS2;
        ALUOp       = c_ALUOP_SUB;
        PCSource    = 1'b1;
        PCWriteCond = 1'b1;
        w_next      = ST_FETCH;
      end

      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (r_class == CL_LOAD);
        MemWrite = (r_class == CL_STORE);
        if (mem_ready) begin
          w_next = (r_class == CL_LOAD) ? ST_WB : ST_FETCH;
        end
      end

      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (r_class == CL_LOAD);
        w_next   = ST_FETCH;
      end

      ST_TRAP: begin
        w_next = ST_TRAP;
      end

      default: begin
        w_next = ST_FETCH;
      end
    endcase

    // Outputs are squashed combinationally while reset is held so that an
    // in-flight memory write is withdrawn without waiting for a clock edge,
    // and FETCH does not issue a read before reset is released.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      PCSource    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = c_SRCB_RS2;
      ALUOp       = c_ALUOP_ADD;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic        w_retire;

  // An instruction retires on every transition back to FETCH
  assign w_retire = (r_state == ST_BRANCH) ||
                    (r_state == ST_WB) ||
                    ((r_state == ST_MEM) && (r_class == CL_STORE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != ST_TRAP) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_retire) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  // Counters are not built in this configuration.
`endif

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is expanded into a per-cycle list of {stimulus, expected
//               outputs} pushed onto a scoreboard queue, then replayed cycle
//               by cycle with outputs compared before the next rising edge.
//               Counter checks are built when PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, PCSource, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .PCSource    (PCSource),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .illegal     (illegal)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic        zr;
    logic        mr;
    logic [14:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Output bundle order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegWrite
  // PCSource ALUSrcA ALUSrcB[1:0] ALUOp[1:0] illegal
  function automatic logic [14:0] vec(input logic pcw, input logic pcwc,
                                      input logic iord, input logic mrd,
                                      input logic mwr, input logic irw,
                                      input logic m2r, input logic rw,
                                      input logic pcs, input logic asa,
                                      input logic [1:0] asb,
                                      input logic [1:0] aop,
                                      input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, pcs, asa, asb, aop, ill};
  endfunction

  function automatic logic [14:0] obs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, illegal};
  endfunction

  function automatic void push(input logic [6:0] opc, input logic zr,
                               input logic mr, input logic [14:0] exp,
                               input string tag);
    item_t it;
    it.opc = opc; it.zr = zr; it.mr = mr; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endfunction

  // Expand one instruction into its expected cycle sequence. fw / mw are the
  // number of mem_ready=0 cycles inserted in FETCH / MEM. Cycles where
  // mem_ready has no meaning get a random value.
  function automatic void push_instr(input logic [6:0] opc, input logic zr,
                                     input int fw, input int mw);
    logic rnd;
    for (int i = 0; i < fw; i++)
      push(opc, zr, 1'b0, vec(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,0), "fetch_wait");
    push(opc, zr, 1'b1, vec(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,0), "fetch");
    rnd = 1'($urandom_range(0, 1));
    push(opc, zr, rnd, vec(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0), "decode");
    rnd = 1'($urandom_range(0, 1));
    case (opc)
      OPC_LOAD, OPC_STORE: begin
        logic ld;
        ld = (opc == OPC_LOAD);
        push(opc, zr, rnd, vec(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0), "exec_mem");
        for (int i = 0; i < mw; i++)
          push(opc, zr, 1'b0, vec(0,0,1,ld,!ld,0,0,0,0,0,2'b00,2'b00,0), "mem_wait");
        push(opc, zr, 1'b1, vec(0,0,1,ld,!ld,0,0,0,0,0,2'b00,2'b00,0), "mem_done");
        if (ld) begin
          rnd = 1'($urandom_range(0, 1));
          push(opc, zr, rnd, vec(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,0), "wb_load");
        end
      end
      OPC_RTYPE: begin
        push(opc, zr, rnd, vec(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0), "exec_r");
        rnd = 1'($urandom_range(0, 1));
        push(opc, zr, rnd, vec(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,0), "wb_alu");
      end
      OPC_ITYPE: begin
        push(opc, zr, rnd, vec(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,0), "exec_i");
        rnd = 1'($urandom_range(0, 1));
        push(opc, zr, rnd, vec(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,0), "wb_alu");
      end
      OPC_BRANCH: begin
        push(opc, zr, rnd, vec(0,1,0,0,0,0,0,0,1,1,2'b00,2'b01,0), "branch");
      end
      default: begin
        for (int i = 0; i < 10; i++) begin
          rnd = 1'($urandom_range(0, 1));
          push(opc, zr, rnd, vec(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1), "trap");
        end
      end
    endcase
  endfunction

  task automatic apply(input item_t it);
    opcode    = it.opc;
    zero      = it.zr;
    mem_ready = it.mr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OPC_RTYPE;
    #1;
    n_vec++;
    if (obs() !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs(), 15'd0);
    end
    tick();
    #1;
    n_vec++;
    if (obs() !== 15'd0) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", obs(), 15'd0);
    end
`ifdef PERF_CNT_EN
    n_vec++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    item_t it;
    push_instr(OPC_RTYPE, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL rtype %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    item_t it;
    push_instr(OPC_LOAD, 1'b0, 0, 2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL load_wait %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    item_t it;
    push_instr(OPC_BRANCH, 1'b0, 0, 0);
    push_instr(OPC_BRANCH, 1'b1, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL branch %s zero=%0b: got %b want %b", it.tag, it.zr, obs(), it.exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    item_t it;
    push_instr(OPC_ITYPE,  1'b0, 0, 0);
    push_instr(OPC_STORE,  1'b0, 1, 1);
    push_instr(OPC_LOAD,   1'b1, 2, 0);
    push_instr(OPC_RTYPE,  1'b1, 0, 0);
    push_instr(OPC_BRANCH, 1'b0, 3, 0);
    push_instr(OPC_STORE,  1'b1, 0, 3);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL b2b %s opc=%b: got %b want %b", it.tag, it.opc, obs(), it.exp);
      end
      tick();
    end
  endtask

  task automatic test_trap();
    item_t it;
    push_instr(OPC_JAL, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL trap %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== 15'd0) begin
      n_err++;
      $display("FAIL trap_clear: got %b want %b", obs(), 15'd0);
    end
    tick();
    rst_n = 1'b1;
    push_instr(OPC_RTYPE, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL trap_restart %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    item_t it;
    logic [14:0] mem_st;
    mem_st = vec(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,0);
    // Run sh up to the first MEM cycle, holding mem_ready low there.
    push_instr(OPC_STORE, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL async_rst %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
    sb.delete();
    mem_ready = 1'b0;
    #1;
    n_vec++;
    if (obs() !== mem_st) begin
      n_err++;
      $display("FAIL async_rst mem_hold: got %b want %b", obs(), mem_st);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (MemWrite !== 1'b0 || obs() !== 15'd0) begin
      n_err++;
      $display("FAIL async_rst drop: got %b want %b", obs(), 15'd0);
    end
    tick();
    rst_n = 1'b1;
    push_instr(OPC_RTYPE, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL async_rst restart %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    item_t it;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) push_instr(OPC_ITYPE, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL perf %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
    #1;
    n_vec++;
    if (instret_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
      n_err++;
      $display("FAIL perf_counts: got instret=%0d cycle=%0d want 3/12", instret_cnt, cycle_cnt);
    end
    force dut.r_cycle_cnt   = 32'hFFFF_FFFF;
    force dut.r_instret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_cnt;
    release dut.r_instret_cnt;
    mem_ready = 1'b0;
    opcode    = OPC_RTYPE;
    tick();
    #1;
    n_vec++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL perf_cycle_wrap: got cycle=%h instret=%h want 0/ffffffff", cycle_cnt, instret_cnt);
    end
    push_instr(OPC_RTYPE, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      #1;
      n_vec++;
      if (obs() !== it.exp) begin
        n_err++;
        $display("FAIL perf_wrap %s: got %b want %b", it.tag, obs(), it.exp);
      end
      tick();
    end
    #1;
    n_vec++;
    if (cycle_cnt !== 32'd4 || instret_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL perf_instret_wrap: got cycle=%0d instret=%h want 4/0", cycle_cnt, instret_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_vec=%0d)", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_trap();
    test_async_reset();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multicycle_control
`default_nettype wire
